// File: rtl/fuel_sensor_filter.sv
// Fuel sensor front end: rejects out-of-range raw samples, smooths good ones with a
// 4-deep moving average, flags refuel jumps and keeps a hysteretic sensor fault flag.
module fuel_sensor_filter #(
  parameter int unsigned FUEL_W       = 5,
  parameter int unsigned RAW_W        = 6,
  parameter int unsigned REFUEL_DELTA = 4,
  parameter int unsigned FAULT_CNT    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [RAW_W-1:0]  raw_level,
  output logic [FUEL_W-1:0] fuel_level,
  output logic              fuel_valid,
  output logic              window_full,
  output logic              refuel_event,
  output logic              sensor_fault
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned SUM_W  = FUEL_W + 2;
  localparam int unsigned FILL_W = 3;
  localparam int unsigned FLT_W  = $clog2(FAULT_CNT + 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t            state_q, state_d;
  logic [FUEL_W-1:0] buf_q [DEPTH];
  logic [FUEL_W-1:0] buf_d [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FLT_W-1:0]  good_q, good_d, bad_q, bad_d;
  logic [FUEL_W-1:0] level_q, level_d;
  logic              valid_q, valid_d, full_q, full_d, refuel_q, refuel_d, fault_q, fault_d;

  logic              in_range_c, good_c, bad_c, refuel_hit_c;
  logic [FUEL_W-1:0] sample_c;
  logic [SUM_W-1:0]  sum_nxt_c;

  assign in_range_c   = (raw_level <= RAW_W'((1 << FUEL_W) - 1));
  assign good_c       = sample_valid && in_range_c;
  assign bad_c        = sample_valid && !in_range_c;
  assign sample_c     = raw_level[FUEL_W-1:0];
  assign sum_nxt_c    = sum_q - SUM_W'(buf_q[wp_q]) + SUM_W'(sample_c);
  // Threshold evaluated at raw width so level + delta cannot wrap
  assign refuel_hit_c = (state_q == RUN) &&
                        (raw_level >= RAW_W'(level_q) + RAW_W'(REFUEL_DELTA));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    sum_d    = sum_q;
    wp_d     = wp_q;
    fill_d   = fill_q;
    good_d   = good_q;
    bad_d    = bad_q;
    level_d  = level_q;
    full_d   = full_q;
    fault_d  = fault_q;
    valid_d  = 1'b0;
    refuel_d = 1'b0;

    if (bad_c) begin
      bad_d  = (bad_q == FLT_W'(FAULT_CNT)) ? bad_q : bad_q + FLT_W'(1);
      good_d = '0;
      if (bad_d == FLT_W'(FAULT_CNT)) fault_d = 1'b1;
    end else if (good_c) begin
      good_d  = (good_q == FLT_W'(FAULT_CNT)) ? good_q : good_q + FLT_W'(1);
      bad_d   = '0;
      if (good_d == FLT_W'(FAULT_CNT)) fault_d = 1'b0;
      valid_d = 1'b1;

      if (refuel_hit_c) begin
        for (int i = 0; i < DEPTH; i++) buf_d[i] = sample_c;
        sum_d    = SUM_W'({sample_c, 2'b00});
        wp_d     = '0;
        level_d  = sample_c;
        refuel_d = 1'b1;
      end else begin
        buf_d[wp_q] = sample_c;
        sum_d       = sum_nxt_c;
        wp_d        = wp_q + PTR_W'(1);
        unique case (state_q)
          FILL: begin
            fill_d = fill_q + FILL_W'(1);
            unique case (fill_q)
              FILL_W'(0): level_d = sample_c;
              FILL_W'(1): level_d = FUEL_W'(sum_nxt_c >> 1);
              FILL_W'(2): level_d = FUEL_W'(sum_nxt_c / SUM_W'(3));
              default: begin
                level_d = FUEL_W'(sum_nxt_c >> 2);
                state_d = RUN;
                full_d  = 1'b1;
              end
            endcase
          end
          RUN:     level_d = FUEL_W'(sum_nxt_c >> 2);
          default: state_d = FILL;
        endcase
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FILL;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum_q    <= '0;
      wp_q     <= '0;
      fill_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      refuel_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      sum_q    <= sum_d;
      wp_q     <= wp_d;
      fill_q   <= fill_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      refuel_q <= refuel_d;
      fault_q  <= fault_d;
    end
  end

  assign fuel_level   = level_q;
  assign fuel_valid   = valid_q;
  assign window_full  = full_q;
  assign refuel_event = refuel_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_fuel_sensor_filter.sv
// Self-checking bench for fuel_sensor_filter: directed scenarios plus random traffic
// compared against a sample-history model of the filter.
module tb_fuel_sensor_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_valid = 1'b0;
  logic [5:0] raw_level = '0;
  logic [4:0] fuel_level;
  logic       fuel_valid, window_full, refuel_event, sensor_fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: good samples currently in the averaging window
  int q[$];
  int m_level, m_bad_run, m_good_run;
  bit m_run, m_fault, m_valid, m_refuel;

  fuel_sensor_filter dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .raw_level    (raw_level),
    .fuel_level   (fuel_level),
    .fuel_valid   (fuel_valid),
    .window_full  (window_full),
    .refuel_event (refuel_event),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_level = 0; m_bad_run = 0; m_good_run = 0;
    m_run = 0; m_fault = 0; m_valid = 0; m_refuel = 0;
  endtask

  task automatic model_step(input bit v, input int raw);
    int sum;
    m_valid = 0;
    m_refuel = 0;
    if (!v) return;
    if (raw >= 32) begin
      m_bad_run++;
      m_good_run = 0;
      if (m_bad_run >= 3) m_fault = 1;
      return;
    end
    m_good_run++;
    m_bad_run = 0;
    if (m_good_run >= 3) m_fault = 0;
    m_valid = 1;
    if (m_run && raw >= m_level + 4) begin
      q.delete();
      repeat (4) q.push_back(raw);
      m_level  = raw;
      m_refuel = 1;
    end else begin
      q.push_back(raw);
      if (q.size() > 4) void'(q.pop_front());
      sum = 0;
      foreach (q[i]) sum += q[i];
      m_level = sum / q.size();
      if (q.size() == 4) m_run = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".level"},  int'(fuel_level),   m_level);
    check_eq({tag, ".valid"},  int'(fuel_valid),   int'(m_valid));
    check_eq({tag, ".full"},   int'(window_full),  int'(m_run));
    check_eq({tag, ".refuel"}, int'(refuel_event), int'(m_refuel));
    check_eq({tag, ".fault"},  int'(sensor_fault), int'(m_fault));
  endtask

  // One clock of stimulus, then compare everything one step after the edge
  task automatic step(input bit v, input int raw, input string tag);
    @(negedge clk);
    sample_valid = v;
    raw_level    = 6'(raw);
    @(posedge clk);
    #1;
    model_step(v, raw);
    check_outputs(tag);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Assert reset between edges and check outputs clear without a clock
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lvl_16[4];
    int r, raw;
    bit v;
    lvl_16 = '{19, 18, 17, 16};
    model_reset();
    #12;
    check_outputs("reset");
    reset = 1'b1;

    for (int i = 0; i < 4; i++) step(1, 20, "fill20");
    check_eq("fill20.lvl", int'(fuel_level), 20);
    check_eq("fill20.full", int'(window_full), 1);
    step(0, 0, "idle");

    for (int i = 0; i < 4; i++) begin
      step(1, 16, "drop16");
      check_eq("drop16.const", int'(fuel_level), lvl_16[i]);
    end

    // Partial-window averages including the divide by 3
    do_reset();
    step(1, 31, "part0");
    step(1, 30, "part1");
    step(1, 29, "part2");
    check_eq("part.div3", int'(fuel_level), 30);
    step(1, 0, "part3");

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 10, "at10");
    step(1, 13, "below_delta");
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 10, "at10b");
    step(1, 14, "refuel");
    check_eq("refuel.pulse", int'(refuel_event), 1);
    check_eq("refuel.lvl", int'(fuel_level), 14);
    step(1, 14, "after_refuel");
    check_eq("after_refuel.lvl", int'(fuel_level), 14);

    for (int i = 0; i < 3; i++) step(1, 40, "bad40");
    check_eq("bad40.fault", int'(sensor_fault), 1);
    check_eq("bad40.lvl", int'(fuel_level), 14);
    step(1, 14, "hyst_g");
    step(1, 63, "hyst_b");
    step(1, 14, "hyst_g1");
    step(1, 14, "hyst_g2");
    check_eq("hyst_g2.fault", int'(sensor_fault), 1);
    step(1, 14, "hyst_g3");
    check_eq("hyst_g3.fault", int'(sensor_fault), 0);

    async_reset("async");
    step(1, 7, "fresh7");
    check_eq("fresh7.lvl", int'(fuel_level), 7);
    check_eq("fresh7.full", int'(window_full), 0);

    // Random traffic, biased around the current level to exercise refuels and drops
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      v = ($urandom_range(0, 3) != 0);
      if (r < 15)      raw = 32 + int'($urandom_range(0, 31));
      else if (r < 30) raw = int'($urandom_range(0, 31));
      else begin
        raw = m_level + int'($urandom_range(0, 9)) - 4;
        if (raw < 0)  raw = 0;
        if (raw > 31) raw = 31;
      end
      if (r == 99) async_reset("rnd_async");
      else         step(v, raw, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1);
  end

endmodule
